sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra SRAM cycles held per 16-bit access phase; legal range 0..7.
REQ-002 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port wr_en  input  1  store request from the MEM stage.
REQ-005 The module SHALL have port rd_en  input  1  load request from the MEM stage.
REQ-006 The module SHALL have port address  input  32  byte address, which is the ALU result.
REQ-007 The module SHALL have port write_data  input  32  store value, which is val_Rm.
REQ-008 The module SHALL have port read_data  output  32  load result, registered.
REQ-009 The module SHALL have port ready  output  1  high means the pipeline may advance; low freezes IF/ID/EXE/MEM registers.
REQ-010 The module SHALL have port sram_dq  inout  16  SRAM data bus.
REQ-011 The module SHALL have port sram_addr  output  18  SRAM halfword address.
REQ-012 The module SHALL have ports sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Function
REQ-013 The FSM SHALL have the states IDLE, LOW, HIGH and DONE. IDLE→LOW occurs on (rd_en|wr_en). LOW→HIGH and HIGH→DONE each occur after WAIT_CYCLES+1 cycles, counted by a 3-bit counter that clears on every state entry. DONE→IDLE is unconditional.
REQ-014 ready SHALL be combinational: 1 in IDLE with rd_en=wr_en=0, 1 in DONE, and 0 otherwise.
REQ-015 If a request is first seen in cycle 0, ready SHALL be 1 in cycle 2*WAIT_CYCLES+3; with the default this is cycle 5.
REQ-016 The controller SHALL compute word = effective address >> 2. sram_addr SHALL be {word[16:0],0} in LOW, {word[16:0],1} in HIGH, and 0 otherwise.
REQ-017 For a write, sram_dq SHALL be driven with write_data[15:0] in LOW and write_data[31:16] in HIGH. sram_we_n SHALL be 0 in every phase cycle except the last, so the data is stable at the rising edge of we_n.
REQ-018 For a read, sram_dq SHALL be high-Z and sram_oe_n SHALL be 0 in LOW and HIGH. read_data[15:0] SHALL be captured on the last LOW cycle and read_data[31:16] on the last HIGH cycle.
REQ-019 read_data SHALL hold its value until the next read completes; a write SHALL NOT alter it.
REQ-020 If rd_en and wr_en are both 1, the access SHALL be treated as a write.
REQ-021 The operation type and the inputs SHALL be latched on the IDLE→LOW transition. Input changes during LOW or HIGH SHALL be ignored.
REQ-022 sram_ce_n, sram_ub_n and sram_lb_n SHALL be 0 in LOW and HIGH and 1 otherwise. Outside a write phase, sram_we_n SHALL be 1 and sram_dq SHALL be high-Z.
REQ-023 In DONE, a new request SHALL NOT be accepted. Requests are sampled only in IDLE, so back-to-back accesses are separated by one IDLE cycle.

Reset
REQ-024 When rst is asserted, whether idle or mid-operation, the following SHALL take effect immediately: state=IDLE, counter=0, latched inputs=0, read_data=0, all SRAM strobes=1, sram_addr=0 and sram_dq high-Z. A partially written word SHALL be left as is, with no rollback.
REQ-025 ready SHALL follow REQ-014 during reset.

Configuration
REQ-026 With MEM_ADDR_OFFSET_EN defined, the effective address SHALL be address − 32'd1024, so that data memory starts at byte 1024. Without it, the effective address SHALL be address unchanged.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (2 bits), the SRAM_ADDR_W=18 and SRAM_DATA_W=16 constants, and the MEM_BASE_ADDR=1024 constant.
REQ-028 One sub-module, sram_phase_counter, SHALL be used: a wait-cycle counter with a clear input and a done flag. The rest SHALL be flat.

Verification
REQ-029 Scenario 1, write, with WAIT_CYCLES=1 and MEM_ADDR_OFFSET_EN undefined: wr_en=1, address=0x10, write_data=0xDEADBEEF. Required: sram_addr=8 with dq=0xBEEF, then sram_addr=9 with dq=0xDEAD, and ready=1 at cycle 5.
REQ-030 Scenario 2, read back the same address. Required: read_data=0xDEADBEEF at cycle 5, and sram_dq is never driven.
REQ-031 Scenario 3, rd_en=wr_en=1 with write_data=0x12345678 at 0x20, followed by a read of 0x20. Required: the write is performed and the read returns 0x12345678.
REQ-032 Scenario 4, rst pulsed in cycle 3 of a write. Required: state is IDLE immediately, sram_we_n=1, dq is Z and read_data=0. A new read completes normally afterwards.
REQ-033 Scenario 5, MEM_ADDR_OFFSET_EN defined, write at address 1028. Required: sram_addr sequence 2 then 3.
REQ-034 Scenario 6, WAIT_CYCLES=0, two back-to-back reads. Required: ready=1 at cycle 3, one IDLE cycle, then the second access starts; address changes during HIGH do not affect sram_addr.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic [31:0] MEM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller_phase_counter.sv
// Wait-cycle counter for one 16-bit access phase; done marks the last cycle of the phase.
module sram_phase_counter
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done,
  output logic done_next
);

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!done) begin
      count_d = count_q + 3'd1;
    end
  end

  assign done      = (count_q == LAST);
  // Lets the caller register strobes that depend on next cycle being the last one.
  assign done_next = (count_d == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit async SRAM, low halfword first then high halfword.
// Build option MEM_ADDR_OFFSET_EN: data memory starts at byte MEM_BASE_ADDR.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  logic [SRAM_DATA_W-1:0] sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  state_e                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [16:0]            word_q, word_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   ce_n_q, ce_n_d;
  logic                   dq_oe_q, dq_oe_d;
  logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
  logic [31:0]            eff_addr;
  logic                   cnt_clear, cnt_done, cnt_done_next;
  logic                   phase_d;
  logic                   unused_addr_bits;

`ifdef MEM_ADDR_OFFSET_EN
  assign eff_addr = address - MEM_BASE_ADDR;
`else
  assign eff_addr = address;
`endif
  assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .done      (cnt_done),
    .done_next (cnt_done_next)
  );

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ST_LOW;
          op_wr_d = wr_en;
          word_d  = eff_addr[18:2];
          wdata_d = write_data;
        end
      end
      ST_LOW: begin
        if (cnt_done) begin
          state_d = ST_HIGH;
          if (!op_wr_q) read_data_d[15:0] = sram_dq;
        end
      end
      ST_HIGH: begin
        if (cnt_done) begin
          state_d = ST_DONE;
          if (!op_wr_q) read_data_d[31:16] = sram_dq;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_clear = (state_d != state_q) || (state_q == ST_IDLE);

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    phase_d  = (state_d == ST_LOW) || (state_d == ST_HIGH);
    ce_n_d   = !phase_d;
    oe_n_d   = !(phase_d && !op_wr_d);
    we_n_d   = !(phase_d && op_wr_d && !cnt_done_next);
    dq_oe_d  = phase_d && op_wr_d;
    dq_out_d = (state_d == ST_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
    addr_d   = '0;
    if (phase_d) addr_d = {word_d, (state_d == ST_HIGH)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
  assign read_data = read_data_q;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_ce_n = ce_n_q;
  assign sram_ub_n = ce_n_q;
  assign sram_lb_n = ce_n_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: one instance at WAIT_CYCLES=1, one at WAIT_CYCLES=0.
`timescale 1ns/1ps
module tb_sram_controller;

`ifdef MEM_ADDR_OFFSET_EN
  localparam logic [31:0] OFS   = 32'd1024;
  localparam logic [31:0] S5_LO = 32'd2;
  localparam logic [31:0] S5_HI = 32'd3;
`else
  localparam logic [31:0] OFS   = 32'd0;
  localparam logic [31:0] S5_LO = 32'd514;
  localparam logic [31:0] S5_HI = 32'd515;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  logic        wr_en_z, rd_en_z;
  logic [31:0] address_z, write_data_z, read_data_z;
  logic        ready_z;
  wire  [15:0] sram_dq_z;
  logic [17:0] sram_addr_z;
  logic        we_n_z, oe_n_z, ce_n_z, ub_n_z, lb_n_z;

  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  int n_checks = 0;
  int n_fail   = 0;

  sram_controller #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
    .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_ce_n(ce_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  sram_controller #(.WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en_z), .rd_en(rd_en_z), .address(address_z),
    .write_data(write_data_z), .read_data(read_data_z), .ready(ready_z), .sram_dq(sram_dq_z),
    .sram_addr(sram_addr_z), .sram_we_n(we_n_z), .sram_oe_n(oe_n_z), .sram_ce_n(ce_n_z),
    .sram_ub_n(ub_n_z), .sram_lb_n(lb_n_z)
  );

  // Async SRAM models
  assign sram_dq   = (!ce_n && !oe_n) ? mem_a[sram_addr] : 16'hzzzz;
  assign sram_dq_z = (!ce_n_z && !oe_n_z) ? mem_b[sram_addr_z] : 16'hzzzz;
  always @(negedge clk) if (!ce_n && !we_n) mem_a[sram_addr] <= sram_dq;
  always @(negedge clk) if (!ce_n_z && !we_n_z) mem_b[sram_addr_z] <= sram_dq_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr_en_z = 0; rd_en_z = 0; address_z = 0; write_data_z = 0;
    mem_b[32] = 16'h1111; mem_b[33] = 16'h2222;
    mem_b[34] = 16'h3333; mem_b[35] = 16'h4444;
    cyc(2);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_ce_n", 32'(ce_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Scenario 1: write 0xDEADBEEF at 0x10
    wr_en = 1; address = OFS + 32'h10; write_data = 32'hDEADBEEF;
    #1 chk("s1_ready_c0", 32'(ready), 32'd0);
    cyc(1);
    wr_en = 0; address = 32'hFFFF_FFF0; write_data = 32'h0;
    chk("s1_addr_c1", 32'(sram_addr), 32'd8);
    chk("s1_dq_c1", 32'(sram_dq), 32'h0000BEEF);
    chk("s1_we_n_c1", 32'(we_n), 32'd0);
    chk("s1_strobes_c1", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
    chk("s1_oe_n_c1", 32'(oe_n), 32'd1);
    cyc(1);
    chk("s1_we_n_c2", 32'(we_n), 32'd1);
    chk("s1_addr_c2", 32'(sram_addr), 32'd8);
    chk("s1_dq_c2", 32'(sram_dq), 32'h0000BEEF);
    cyc(1);
    chk("s1_addr_c3", 32'(sram_addr), 32'd9);
    chk("s1_dq_c3", 32'(sram_dq), 32'h0000DEAD);
    chk("s1_we_n_c3", 32'(we_n), 32'd0);
    cyc(1);
    chk("s1_we_n_c4", 32'(we_n), 32'd1);
    chk("s1_ready_c4", 32'(ready), 32'd0);
    cyc(1);
    chk("s1_ready_c5", 32'(ready), 32'd1);
    chk("s1_ce_n_c5", 32'(ce_n), 32'd1);
    chk("s1_addr_c5", 32'(sram_addr), 32'd0);
    chk("s1_mem_lo", 32'(mem_a[8]), 32'h0000BEEF);
    chk("s1_mem_hi", 32'(mem_a[9]), 32'h0000DEAD);
    cyc(1);

    // Scenario 2: read back 0x10
    rd_en = 1; address = OFS + 32'h10;
    cyc(1);
    rd_en = 0;
    chk("s2_addr_c1", 32'(sram_addr), 32'd8);
    chk("s2_oe_n_c1", 32'(oe_n), 32'd0);
    chk("s2_we_n_c1", 32'(we_n), 32'd1);
    cyc(1);
    chk("s2_we_n_c2", 32'(we_n), 32'd1);
    cyc(1);
    chk("s2_addr_c3", 32'(sram_addr), 32'd9);
    chk("s2_we_n_c3", 32'(we_n), 32'd1);
    cyc(1);
    chk("s2_we_n_c4", 32'(we_n), 32'd1);
    cyc(1);
    chk("s2_ready_c5", 32'(ready), 32'd1);
    chk("s2_rdata_c5", read_data, 32'hDEADBEEF);
    chk("s2_oe_n_c5", 32'(oe_n), 32'd1);
    cyc(1);

    // Scenario 3: rd_en and wr_en together is a write
    rd_en = 1; wr_en = 1; address = OFS + 32'h20; write_data = 32'h12345678;
    cyc(1);
    rd_en = 0; wr_en = 0;
    chk("s3_we_n_c1", 32'(we_n), 32'd0);
    chk("s3_oe_n_c1", 32'(oe_n), 32'd1);
    chk("s3_addr_c1", 32'(sram_addr), 32'd16);
    chk("s3_dq_c1", 32'(sram_dq), 32'h00005678);
    cyc(2);
    chk("s3_addr_c3", 32'(sram_addr), 32'd17);
    chk("s3_dq_c3", 32'(sram_dq), 32'h00001234);
    cyc(2);
    chk("s3_ready_c5", 32'(ready), 32'd1);
    chk("s3_rdata_kept", read_data, 32'hDEADBEEF);
    cyc(1);
    rd_en = 1; address = OFS + 32'h20;
    cyc(1);
    rd_en = 0;
    cyc(4);
    chk("s3_rdata_c5", read_data, 32'h12345678);
    cyc(1);

    // Scenario 4: reset in cycle 3 of a write
    wr_en = 1; address = OFS + 32'h30; write_data = 32'hCAFEF00D;
    cyc(1);
    wr_en = 0;
    cyc(1);
    @(posedge clk); #1;
    chk("s4_we_n_pre", 32'(we_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("s4_we_n_rst", 32'(we_n), 32'd1);
    chk("s4_ce_n_rst", 32'(ce_n), 32'd1);
    chk("s4_oe_n_rst", 32'(oe_n), 32'd1);
    chk("s4_addr_rst", 32'(sram_addr), 32'd0);
    chk("s4_rdata_rst", read_data, 32'd0);
    chk("s4_ready_rst", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("s4_partial_lo", 32'(mem_a[24]), 32'h0000F00D);
    cyc(1);
    rd_en = 1; address = OFS + 32'h10;
    cyc(1);
    rd_en = 0;
    cyc(4);
    chk("s4_ready_c5", 32'(ready), 32'd1);
    chk("s4_rdata_c5", read_data, 32'hDEADBEEF);
    cyc(1);

    // Scenario 5: write at byte 1028
    wr_en = 1; address = 32'd1028; write_data = 32'hA5A55A5A;
    cyc(1);
    wr_en = 0;
    chk("s5_addr_lo", 32'(sram_addr), S5_LO);
    chk("s5_dq_lo", 32'(sram_dq), 32'h00005A5A);
    cyc(2);
    chk("s5_addr_hi", 32'(sram_addr), S5_HI);
    chk("s5_dq_hi", 32'(sram_dq), 32'h0000A5A5);
    cyc(2);
    chk("s5_ready_c5", 32'(ready), 32'd1);
    cyc(1);

    // Scenario 6: WAIT_CYCLES=0, back-to-back reads
    rd_en_z = 1; address_z = OFS + 32'h40;
    #1 chk("s6_ready_c0", 32'(ready_z), 32'd0);
    cyc(1);
    chk("s6_addr_c1", 32'(sram_addr_z), 32'd32);
    chk("s6_oe_n_c1", 32'(oe_n_z), 32'd0);
    chk("s6_we_n_c1", 32'(we_n_z), 32'd1);
    chk("s6_ublb_c1", {30'd0, ub_n_z, lb_n_z}, 32'd0);
    address_z = OFS + 32'h44;
    cyc(1);
    chk("s6_addr_c2", 32'(sram_addr_z), 32'd33);
    chk("s6_ready_c2", 32'(ready_z), 32'd0);
    cyc(1);
    chk("s6_ready_c3", 32'(ready_z), 32'd1);
    chk("s6_rdata_1", read_data_z, 32'h22221111);
    chk("s6_ce_n_c3", 32'(ce_n_z), 32'd1);
    cyc(1);
    chk("s6_ready_idle", 32'(ready_z), 32'd0);
    chk("s6_ce_n_idle", 32'(ce_n_z), 32'd1);
    chk("s6_addr_idle", 32'(sram_addr_z), 32'd0);
    cyc(1);
    rd_en_z = 0;
    chk("s6_addr_c5", 32'(sram_addr_z), 32'd34);
    cyc(1);
    chk("s6_addr_c6", 32'(sram_addr_z), 32'd35);
    cyc(1);
    chk("s6_ready_c7", 32'(ready_z), 32'd1);
    chk("s6_rdata_2", read_data_z, 32'h44443333);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
